// File: rtl/watch_pkg.sv
// watch_pkg: register map, CTRL/STATUS bit indices, 7-segment codes and BCD time helpers.
package watch_pkg;

    localparam logic [1:0] ADDR_TIME   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_ALARM  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_MODE12 = 1;
    localparam int CTRL_BLANK  = 2;
    localparam int CTRL_ALEN   = 3;
    localparam int ST_ERR      = 0;
    localparam int ST_ALARM    = 1;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // {h1,h0,m1,m0,s1,s0}: every nibble a decimal digit, hours <= 23, minutes/seconds <= 59
    function automatic logic time_valid(input logic [23:0] t);
        return t[23:20] <= 4'd2 && t[19:16] <= 4'd9 && (t[23:20] != 4'd2 || t[19:16] <= 4'd3) &&
               t[15:12] <= 4'd5 && t[11:8] <= 4'd9 && t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
    endfunction

    function automatic logic [23:0] time_inc(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        logic c;
        {h1, h0, m1, m0, s1, s0} = t;
        c = s0 == 4'd9;
        s0 = c ? 4'd0 : s0 + 4'd1;
        if (c) begin
            c = s1 == 4'd5;
            s1 = c ? 4'd0 : s1 + 4'd1;
        end
        if (c) begin
            c = m0 == 4'd9;
            m0 = c ? 4'd0 : m0 + 4'd1;
        end
        if (c) begin
            c = m1 == 4'd5;
            m1 = c ? 4'd0 : m1 + 4'd1;
        end
        if (c) begin
            if (h1 == 4'd2 && h0 == 4'd3) {h1, h0} = 8'h00;
            else if (h0 == 4'd9) {h1, h0} = {h1 + 4'd1, 4'd0};
            else h0 = h0 + 4'd1;
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high segments {g..a}; non-decimal codes go dark.
module seg7_decode
    import watch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/watch_core_multi.sv
// watch_core_multi: BCD HH:MM:SS watch with 12/24h display, register port and registered 7-seg bus.
// Optional alarm register and compare enabled by defining WATCH_ALARM_EN.
module watch_core_multi
    import watch_pkg::*;
#(
    parameter  int TICK_DIV = 32768,
    parameter  int SHOW_SEC = 1,
    localparam int N_DIGITS = SHOW_SEC ? 6 : 4
) (
    input  logic                  sysclk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            addr_i,
    input  logic [23:0]           wdata_i,
    output logic                  ack_o,
    output logic [23:0]           rdata_o,
    output logic                  pm_o,
    output logic                  alarm_o,
    output logic [7*N_DIGITS-1:0] seg_o
);

`ifdef WATCH_ALARM_EN
    localparam bit         ALARM_EN  = 1'b1;
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam bit         ALARM_EN  = 1'b0;
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif
    localparam int PW = $clog2(TICK_DIV);

    logic [23:0]           time_q, time_d, rdata_q, rdata_d, disp;
    logic [PW-1:0]         pre_q, pre_d;
    logic [3:0]            ctrl_q, ctrl_d, dh1;
    logic [15:0]           alrm_q, alrm_d;
    logic                  err_q, err_d, alarm_q, alarm_d, ack_q, pm_q, pm_d;
    logic [7*N_DIGITS-1:0] seg_q, seg_d, seg_w;
    logic [4*N_DIGITS-1:0] digits;
    logic [4:0]            hb, dh, dt;
    logic                  wr, tick, time_wr, wr_ok, alrm_wr, alrm_ok, match, mode12;

    always_comb begin
        wr      = req_i && we_i;
        tick    = ctrl_q[CTRL_RUN] && pre_q == PW'(TICK_DIV - 1);
        time_wr = wr && addr_i == ADDR_TIME;
        wr_ok   = time_wr && time_valid(wdata_i);
        alrm_wr = ALARM_EN && wr && addr_i == ADDR_ALARM;
        alrm_ok = time_valid({wdata_i[15:0], 8'h00});
        // a valid time write overrides a coincident tick and restarts the second
        pre_d   = (wr_ok || tick) ? '0 : pre_q + PW'(ctrl_q[CTRL_RUN]);
        time_d  = wr_ok ? wdata_i : tick ? time_inc(time_q) : time_q;
        ctrl_d  = (wr && addr_i == ADDR_CTRL) ? wdata_i[3:0] & CTRL_MASK : ctrl_q;
        alrm_d  = (alrm_wr && alrm_ok) ? wdata_i[15:0] : alrm_q;
        err_d   = ((time_wr && !wr_ok) || (alrm_wr && !alrm_ok)) ? 1'b1 :
                  (wr && addr_i == ADDR_STATUS && wdata_i[ST_ERR]) ? 1'b0 : err_q;
        match   = ALARM_EN && ctrl_q[CTRL_ALEN] && (wr_ok || tick) && time_d == {alrm_q, 8'h00};
        alarm_d = match || (alarm_q && ctrl_d[CTRL_ALEN] &&
                  !(wr && addr_i == ADDR_STATUS && wdata_i[ST_ALARM]));
        rdata_d = (req_i && !we_i) ?
                  (addr_i == ADDR_TIME ? time_q :
                   addr_i == ADDR_CTRL ? {20'h0, ctrl_q} :
                   addr_i == ADDR_ALARM ? {8'h0, alrm_q} : {22'h0, alarm_q, err_q}) : rdata_q;
        mode12  = ctrl_q[CTRL_MODE12];
        hb      = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
        dh      = !mode12 ? hb : hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
        dh1     = dh >= 5'd20 ? 4'd2 : dh >= 5'd10 ? 4'd1 : 4'd0;
        dt      = dh >= 5'd20 ? 5'd20 : dh >= 5'd10 ? 5'd10 : 5'd0;
        disp    = {dh1, 4'(dh - dt), time_q[15:0]};
        pm_d    = mode12 && hb >= 5'd12;
        seg_d   = ctrl_q[CTRL_BLANK] ? '0 : seg_w;
    end

    assign digits = disp[23 -: 4*N_DIGITS];

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
        seg7_decode u_dec (.bcd_i(digits[4*i +: 4]), .seg_o(seg_w[7*i +: 7]));
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            time_q  <= '0;
            pre_q   <= '0;
            ctrl_q  <= '0;
            alrm_q  <= '0;
            err_q   <= 1'b0;
            alarm_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            pm_q    <= 1'b0;
            seg_q   <= {N_DIGITS{SEG_0}};
        end else begin
            time_q  <= time_d;
            pre_q   <= pre_d;
            ctrl_q  <= ctrl_d;
            alrm_q  <= alrm_d;
            err_q   <= err_d;
            alarm_q <= alarm_d;
            ack_q   <= req_i;
            rdata_q <= rdata_d;
            pm_q    <= pm_d;
            seg_q   <= seg_d;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign pm_o    = pm_q;
    assign alarm_o = alarm_q;
    assign seg_o   = seg_q;

endmodule

// File: tb/tb_watch_core_multi.sv
// tb_watch_core_multi: scoreboard bench for watch_core_multi (TICK_DIV=4, SHOW_SEC=1).
module tb_watch_core_multi;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [23:0] wdata = '0;
    logic        ack, pm, alarm;
    logic [23:0] rdata;
    logic [41:0] seg;
    logic        exp_ack = 1'b0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        rd;
        logic [23:0] exp;
        string       tag;
    } sb_t;
    sb_t sb[$];

    watch_core_multi #(.TICK_DIV(4), .SHOW_SEC(1)) dut (
        .sysclk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack), .rdata_o(rdata), .pm_o(pm), .alarm_o(alarm), .seg_o(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) exp_ack <= req && !rst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] s7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [41:0] segs(input logic [23:0] bcd);
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[7*i +: 7] = s7(bcd[4*i +: 4]);
        return r;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (ack || exp_ack) chk("ack_timing", 64'(ack), 64'(exp_ack));
        if (ack) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.rd) chk(e.tag, 64'(rdata), 64'(e.exp));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // callers sit just after a negedge; the access is sampled on the next posedge
    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        sb_t e;
        e.rd = 1'b0; e.exp = '0; e.tag = "wr";
        sb.push_back(e);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [23:0] exp, input string tag);
        sb_t e;
        e.rd = 1'b1; e.exp = exp; e.tag = tag;
        sb.push_back(e);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_seg", 64'(seg), 64'(segs(24'h0)));
        chk("rst_pm", 64'(pm), 64'd0);
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rd(2'd0, 24'h0, "rst_time");
        rd(2'd1, 24'h0, "rst_ctrl");
        rd(2'd3, 24'h0, "rst_status");

        // full-day rollover: two ticks from 23:59:58
        wr(2'd0, 24'h235958);
        wr(2'd1, 24'h1);
        cyc(7);
        wr(2'd1, 24'h0);
        rd(2'd0, 24'h000000, "rollover_time");
        cyc(1);
        chk("rollover_seg", 64'(seg), 64'(segs(24'h0)));

        // invalid minute is rejected and flags err
        wr(2'd0, 24'h126000);
        rd(2'd0, 24'h000000, "bad_time_kept");
        rd(2'd3, 24'h1, "err_set");
        wr(2'd3, 24'h1);
        rd(2'd3, 24'h0, "err_cleared");
        wr(2'd0, 24'h240000);
        rd(2'd3, 24'h1, "err_hour24");
        wr(2'd3, 24'h1);

        // time write on the tick cycle wins
        wr(2'd0, 24'h000000);
        wr(2'd1, 24'h1);
        cyc(3);
        wr(2'd0, 24'h100000);
        rd(2'd0, 24'h100000, "write_beats_tick");
        cyc(3);
        rd(2'd0, 24'h100001, "tick_after_write");
        wr(2'd1, 24'h0);

        // 12h display
        wr(2'd0, 24'h130500);
        wr(2'd1, 24'h2);
        cyc(1);
        chk("m12_13_seg", 64'(seg), 64'(segs(24'h010500)));
        chk("m12_13_pm", 64'(pm), 64'd1);
        wr(2'd0, 24'h000000);
        cyc(1);
        chk("m12_00_seg", 64'(seg), 64'(segs(24'h120000)));
        chk("m12_00_pm", 64'(pm), 64'd0);
        wr(2'd0, 24'h120000);
        cyc(1);
        chk("m12_12_seg", 64'(seg), 64'(segs(24'h120000)));
        chk("m12_12_pm", 64'(pm), 64'd1);
        wr(2'd0, 24'h235959);
        cyc(1);
        chk("m12_23_seg", 64'(seg), 64'(segs(24'h115959)));
        wr(2'd1, 24'h0);
        cyc(1);
        chk("m24_23_seg", 64'(seg), 64'(segs(24'h235959)));
        chk("m24_23_pm", 64'(pm), 64'd0);
        wr(2'd1, 24'h4);
        cyc(1);
        chk("blank_seg", 64'(seg), 64'd0);
        rd(2'd1, 24'h4, "ctrl_blank");

`ifdef WATCH_ALARM_EN
        wr(2'd2, 24'h0701);
        wr(2'd1, 24'h9);
        wr(2'd0, 24'h070059);
        cyc(3);
        chk("alarm_early", 64'(alarm), 64'd0);
        cyc(1);
        chk("alarm_hit", 64'(alarm), 64'd1);
        wr(2'd1, 24'h8);
        rd(2'd3, 24'h2, "status_alarm");
        wr(2'd3, 24'h2);
        chk("alarm_wclr", 64'(alarm), 64'd0);
        wr(2'd0, 24'h070100);
        chk("alarm_on_write", 64'(alarm), 64'd1);
        wr(2'd1, 24'h0);
        chk("alarm_en_clr", 64'(alarm), 64'd0);
        rd(2'd2, 24'h000701, "alarm_reg");
        wr(2'd2, 24'h0760);
        rd(2'd2, 24'h000701, "alarm_bad_kept");
        rd(2'd3, 24'h1, "alarm_bad_err");
        wr(2'd3, 24'h1);
`else
        wr(2'd2, 24'h0701);
        rd(2'd2, 24'h0, "alarm_reads0");
        chk("alarm_tied0", 64'(alarm), 64'd0);
        rd(2'd3, 24'h0, "status_no_alarm");
`endif

        // reset while running and with a read in flight: access dropped
        wr(2'd0, 24'h131415);
        wr(2'd1, 24'h7);
        cyc(3);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 2'd0;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        chk("rst2_ack", 64'(ack), 64'd0);
        chk("rst2_rdata", 64'(rdata), 64'd0);
        chk("rst2_seg", 64'(seg), 64'(segs(24'h0)));
        chk("rst2_pm", 64'(pm), 64'd0);
        chk("rst2_alarm", 64'(alarm), 64'd0);
        cyc(2);
        rd(2'd0, 24'h0, "rst2_time");
        rd(2'd1, 24'h0, "rst2_ctrl");
        rd(2'd3, 24'h0, "rst2_status");
        cyc(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
